// File: rtl/calypto_mem_1p_arb_if.sv
// Client request/response and memory-pin bundle for calypto_mem_1p_arb.
// Index [n] of each two-entry signal belongs to requester port n.
interface calypto_mem_1p_arb_if #(
  parameter int AW = 5,
  parameter int DW = 8
);
  logic [1:0]         rq_vld;
  logic [1:0]         rq_rdy;
  logic [1:0]         rq_rw;
  logic [1:0][AW-1:0] rq_adr;
  logic [1:0][DW-1:0] rq_d;
  logic [1:0][DW-1:0] rq_wm;
  logic [1:0]         rs_vld;
  logic [1:0][DW-1:0] rs_q;
  logic               mem_me;
  logic               mem_rw;
  logic [AW-1:0]      mem_wadr;
  logic [AW-1:0]      mem_radr;
  logic [DW-1:0]      mem_d;
  logic [DW-1:0]      mem_wm;
  logic [DW-1:0]      mem_q;
  logic               mem_ls;
  logic               mem_ds;
  logic               mem_sd;
  logic               busy;

  // arbiter side
  modport slave (
    input  rq_vld, rq_rw, rq_adr, rq_d, rq_wm, mem_q,
    output rq_rdy, rs_vld, rs_q, mem_me, mem_rw, mem_wadr, mem_radr,
           mem_d, mem_wm, mem_ls, mem_ds, mem_sd, busy
  );

  // clients plus the memory instance
  modport master (
    output rq_vld, rq_rw, rq_adr, rq_d, rq_wm, mem_q,
    input  rq_rdy, rs_vld, rs_q, mem_me, mem_rw, mem_wadr, mem_radr,
           mem_d, mem_wm, mem_ls, mem_ds, mem_sd, busy
  );
endinterface

// File: rtl/calypto_mem_1p_arb.sv
// Two-port round-robin arbiter/sequencer for the single-port memory.
// Define MEM_ARB_PWR_EN to build the idle light-sleep FSM (SLEEP/WAKE).
module calypto_mem_1p_arb #(
  parameter int AW       = 5,
  parameter int DW       = 8,
  parameter int IDLE_CYC = 8,
  parameter int WAKE_CYC = 2
) (
  input logic                  clk,
  input logic                  arst_n,
  calypto_mem_1p_arb_if.slave  bus
);

  typedef enum logic [1:0] {ACTIVE = 2'd0, SLEEP = 2'd1, WAKE = 2'd2} state_e;

  if (IDLE_CYC < 1 || WAKE_CYC < 1) begin : g_bad_cfg
    $error("calypto_mem_1p_arb: IDLE_CYC and WAKE_CYC must be >= 1");
  end

  state_e     state_q;
  logic       ptr_q;
  logic [1:0] rs_vld_q;
  logic       any_vld;
  logic       win;
  logic [1:0] rdy;
  logic       gnt;

  assign any_vld = |bus.rq_vld;
  // lone requester wins; ptr only breaks ties
  assign win = (&bus.rq_vld) ? ptr_q : bus.rq_vld[1];
  assign rdy = (arst_n && state_q == ACTIVE && any_vld) ? (2'b01 << win) : 2'b00;
  assign gnt = |rdy;

  assign bus.rq_rdy   = rdy;
  assign bus.mem_me   = gnt;
  assign bus.mem_rw   = gnt & bus.rq_rw[win];
  assign bus.mem_wadr = gnt ? bus.rq_adr[win] : '0;
  assign bus.mem_radr = gnt ? bus.rq_adr[win] : '0;
  assign bus.mem_d    = gnt ? bus.rq_d[win]   : '0;
  assign bus.mem_wm   = gnt ? bus.rq_wm[win]  : '0;
  assign bus.mem_ls   = (state_q == SLEEP);
  assign bus.mem_ds   = 1'b0;
  assign bus.mem_sd   = 1'b0;
  assign bus.busy     = any_vld | (|rs_vld_q) | (state_q == WAKE);

  // response tracking runs regardless of the power state
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ptr_q    <= 1'b0;
      rs_vld_q <= '0;
    end else begin
      rs_vld_q <= rdy & ~bus.rq_rw;
      if (gnt) ptr_q <= ~win;
    end
  end

  assign bus.rs_vld = rs_vld_q;
  for (genvar n = 0; n < 2; n++) begin : g_rs
    assign bus.rs_q[n] = rs_vld_q[n] ? bus.mem_q : '0;
  end

`ifdef MEM_ARB_PWR_EN
  localparam int IW = (IDLE_CYC > 1) ? $clog2(IDLE_CYC) : 1;
  localparam int WW = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYC - 1);
  localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYC - 1);

  state_e        state_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [WW-1:0] wake_q, wake_d;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ACTIVE;
      idle_q  <= '0;
      wake_q  <= '0;
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
      wake_q  <= wake_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    wake_d  = wake_q;
    case (state_q)
      ACTIVE: begin
        if (any_vld) begin
          idle_d = '0;
        end else if (idle_q == IDLE_LAST) begin
          idle_d  = '0;
          state_d = SLEEP;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      SLEEP: begin
        if (any_vld) begin
          state_d = WAKE;
          wake_d  = '0;
        end
      end
      WAKE: begin
        if (wake_q == WAKE_LAST) begin
          state_d = ACTIVE;
          wake_d  = '0;
        end else begin
          wake_d = wake_q + 1'b1;
        end
      end
      default: state_d = ACTIVE;
    endcase
  end
`else
  assign state_q = ACTIVE;
`endif

endmodule
